// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared constants and types for the unified memory-port arbiter:
//   controller state encoding, port-owner encoding, default latency and
//   starvation limit, plus a small helper that sizes counters.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Controller states (encodings kept identical to the legacy defines)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Which pipeline port owns the in-flight access
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int unsigned DEF_MEM_LAT    = 2;
    localparam int unsigned DEF_STARVE_LIM = 4;

    // Bits needed to hold any value in 0..max_val (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while (w < 32 && ((32'd1 << w) <= max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single unified memory port between the instruction-fetch
//   port (IF) and the load/store port (DM). One request is registered at a
//   time, the fixed-latency access is sequenced, and the read data is
//   returned to the owner together with a one-cycle ack pulse.
//
//   Ports
//     clock, reset            : rising-edge clock, synchronous active-high reset
//     if_req/if_addr          : fetch request, held until if_ack
//     if_rdata/if_ack         : registered fetch data and completion pulse
//     if_stall                : if_req & ~if_ack
//     dm_req/dm_we/dm_addr    : data request (we=1 store, 0 load)
//     dm_wdata/dm_wstrb       : store data and byte enables
//     dm_rdata/dm_ack         : registered load data and completion pulse
//     dm_stall                : dm_req & ~dm_ack
//     mem_en/mem_we/mem_addr  : one-cycle access strobe, write enable, address
//     mem_wdata/mem_wstrb     : write data and byte enables
//     mem_rdata               : read data, valid MEM_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_ack,
    output logic                  dm_stall,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LAT_W  = cnt_width(MEM_LAT - 1);
    localparam int unsigned STV_W  = cnt_width(STARVE_LIM);

    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIM);

    state_t              r_state;
    owner_t              r_owner;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [STV_W-1:0]    r_starve_cnt;

    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]   r_mem_wstrb;

    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_if_ack;
    logic                r_dm_ack;

    logic                w_any_req;
    logic                w_grant_dm;

    // DM has priority unless IF has already been passed over STARVE_LIM times
    always_comb begin
        w_any_req  = if_req | dm_req;
        w_grant_dm = dm_req & (~if_req | (r_starve_cnt != STARVE_MAX));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless a state raises them
            r_mem_en <= 1'b0;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_mem_en <= 1'b1;
                        r_state  <= ISSUE;
                        if (w_grant_dm) begin
                            r_owner     <= OWN_DM;
                            r_mem_we    <= dm_we;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                            r_mem_wstrb <= dm_wstrb;
                            // Count DM wins only while IF is actually waiting
                            if (if_req) begin
                                if (r_starve_cnt != STARVE_MAX) begin
                                    r_starve_cnt <= r_starve_cnt + 1'b1;
                                end
                            end else begin
                                r_starve_cnt <= '0;
                            end
                        end else begin
                            r_owner      <= OWN_IF;
                            r_mem_we     <= 1'b0;
                            r_mem_addr   <= if_addr;
                            r_mem_wdata  <= '0;
                            r_mem_wstrb  <= '0;
                            r_starve_cnt <= '0;
                        end
                    end
                end

                ISSUE: begin
                    r_lat_cnt <= LAT_INIT;
                    r_state   <= WAIT;
                end

                WAIT: begin
                    if (r_lat_cnt == '0) begin
                        // mem_rdata is valid on this edge; stores keep old data
                        if (r_owner == OWN_DM) begin
                            if (!r_mem_we) begin
                                r_dm_rdata <= mem_rdata;
                            end
                            r_dm_ack <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_ack   <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end

                DONE: begin
                    // No grant here so a still-high req is not served twice
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ack    = r_dm_ack;

    assign if_stall  = if_req & ~r_if_ack;
    assign dm_stall  = dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Drives mem_port_arbiter with directed scenarios followed by randomized
//   IF/DM traffic and random resets. A fixed-latency memory responder feeds
//   mem_rdata; a transaction-level model predicts grants, timing and data.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned LAT = 2;
    localparam int unsigned LIM = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [SW-1:0] dm_wstrb;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          dm_stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MEM_LAT    (LAT),
        .STARVE_LIM (LIM)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          pv [LAT];
    logic [AW-1:0] pa [LAT];

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    always @(posedge clock) begin
        logic [DW-1:0] w;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = mem_en;
        pa[0] = mem_addr;
        if (mem_en && mem_we) begin
            w = mem_read(mem_addr);
            for (int b = 0; b < SW; b++) begin
                if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            mem[mem_addr] = w;
        end
        // Garbage whenever no response is due, so stray captures show up
        mem_rdata <= pv[LAT-1] ? mem_read(pa[LAT-1]) : {$urandom, $urandom};
    end

    // ---------------- transaction-level reference model ----------------
    int            m_free_at = 0;
    int            m_en_cyc  = -1;
    int            m_ack_cyc = -1;
    int            m_starve  = 0;
    logic          m_own_dm  = 1'b0;
    logic          m_we      = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_wdata   = '0;
    logic [SW-1:0] m_wstrb   = '0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_dm_rdata = '0;

    // Inputs presented during cycle cyc decide what happens at its closing edge
    task automatic decide();
        bit dm_wins;
        if (reset) begin
            m_free_at = cyc + 1;
            m_en_cyc = -1; m_ack_cyc = -1; m_starve = 0; m_own_dm = 1'b0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
            m_if_rdata = '0; m_dm_rdata = '0;
        end else if (cyc >= m_free_at && (if_req || dm_req)) begin
            dm_wins = dm_req && (!if_req || m_starve != LIM);
            if (dm_wins) begin
                m_starve = if_req ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
                m_own_dm = 1'b1; m_we = dm_we; m_addr = dm_addr;
                m_wdata = dm_wdata; m_wstrb = dm_wstrb;
            end else begin
                m_starve = 0; m_own_dm = 1'b0; m_we = 1'b0; m_addr = if_addr;
            end
            m_en_cyc  = cyc + 1;
            m_ack_cyc = cyc + 2 + LAT;
            m_free_at = cyc + 3 + LAT;
        end
    endtask

    task automatic apply();
        if (cyc == m_ack_cyc && !m_we) begin
            if (m_own_dm) m_dm_rdata = mem_read(m_addr);
            else          m_if_rdata = mem_read(m_addr);
        end
    endtask

    task automatic check_outputs();
        bit e_if_ack, e_dm_ack;
        e_if_ack = (cyc == m_ack_cyc) && !m_own_dm;
        e_dm_ack = (cyc == m_ack_cyc) && m_own_dm;
        check_eq("mem_en",   mem_en,   cyc == m_en_cyc);
        check_eq("mem_we",   mem_we,   m_we);
        check_eq("mem_addr", mem_addr, m_addr);
        if (m_we) begin
            check_eq("mem_wdata", mem_wdata, m_wdata);
            check_eq("mem_wstrb", mem_wstrb, m_wstrb);
        end
        check_eq("if_ack",   if_ack,   e_if_ack);
        check_eq("dm_ack",   dm_ack,   e_dm_ack);
        check_eq("if_rdata", if_rdata, m_if_rdata);
        check_eq("dm_rdata", dm_rdata, m_dm_rdata);
        check_eq("if_stall", if_stall, if_req && !e_if_ack);
        check_eq("dm_stall", dm_stall, dm_req && !e_dm_ack);
    endtask

    task automatic tick();
        decide();
        @(posedge clock);
        #1;
        cyc++;
        apply();
        check_outputs();
    endtask

    task automatic wait_ack(input bit on_dm, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (on_dm ? dm_ack : if_ack) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic idle_tick();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        tick();
    endtask

    // ---------------- random traffic agents ----------------
    int if_wait = 0, dm_wait = 0;
    bit if_drop = 0, dm_drop = 0;

    function automatic logic [AW-1:0] rand_addr(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15));
        return base + (a << 3);
    endfunction

    task automatic agents();
        if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
            if_wait = 0; dm_wait = 0; if_drop = 0; dm_drop = 0;
            return;
        end
        reset = 1'b0;

        if (if_drop) begin
            if_req = 1'b0; if_drop = 0;
        end else if (if_req && if_ack) begin
            if_wait = 0;
            if ($urandom_range(0, 1) != 0) if_drop = 1;  // keep req up through DONE
            else if_req = 1'b0;
        end else if (if_req) begin
            if_wait++;
            if ($urandom_range(0, 7) == 0) if_addr = rand_addr(64'h0);
            if (if_wait > 40) begin
                check_eq("if_wait_bound", if_wait, 40);
                if_wait = 0; if_req = 1'b0;
            end
        end
        if (!if_req && $urandom_range(0, 2) != 0) begin
            if_req = 1'b1; if_addr = rand_addr(64'h0);
        end

        if (dm_drop) begin
            dm_req = 1'b0; dm_drop = 0;
        end else if (dm_req && dm_ack) begin
            dm_wait = 0;
            if ($urandom_range(0, 1) != 0) dm_drop = 1;
            else dm_req = 1'b0;
        end else if (dm_req) begin
            dm_wait++;
            if ($urandom_range(0, 7) == 0) dm_addr = rand_addr(64'h3000);
            if (dm_wait > 40) begin
                check_eq("dm_wait_bound", dm_wait, 40);
                dm_wait = 0; dm_req = 1'b0;
            end
        end
        if (!dm_req && $urandom_range(0, 2) != 0) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = rand_addr(64'h3000);
            dm_wdata = {$urandom, $urandom};
            dm_wstrb = SW'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int            lat, t0, n_dm, n_ack;
        bit            got_if;
        logic [DW-1:0] pre, saved;

        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; end
        mem[64'h100] = 64'hD280_0020;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // IF only
        if_req = 1'b1; if_addr = 64'h100; t0 = cyc;
        wait_ack(1'b0, t0, lat);
        check_eq("if_only_lat", lat, 4);
        check_eq("if_only_data", if_rdata, 64'hD280_0020);
        idle_tick();

        // Both requesting: DM first, IF next
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000;
        if_req = 1'b1; if_addr = 64'h104; t0 = cyc;
        wait_ack(1'b1, t0, lat);
        check_eq("both_dm_lat", lat, 4);
        dm_req = 1'b0;
        wait_ack(1'b0, t0, lat);
        check_eq("both_if_lat", lat, 9);
        idle_tick();

        // Store leaves dm_rdata alone, then read back merged bytes
        saved = dm_rdata;
        pre   = mem_read(64'h3008);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h3008;
        dm_wdata = 64'hFFFF; dm_wstrb = 8'h03; t0 = cyc;
        wait_ack(1'b1, t0, lat);
        check_eq("store_lat", lat, 4);
        check_eq("store_rdata_kept", dm_rdata, saved);
        idle_tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h3008; t0 = cyc;
        wait_ack(1'b1, t0, lat);
        check_eq("store_readback", dm_rdata, {pre[63:16], 16'hFFFF});
        idle_tick();

        // Payload change after grant is ignored
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h40; t0 = cyc;
        tick();
        dm_addr = 64'h80;
        tick();
        check_eq("payload_addr", mem_addr, 64'h40);
        wait_ack(1'b1, t0, lat);
        check_eq("payload_lat", lat, 4);
        check_eq("payload_data", dm_rdata, mem_read(64'h40));
        idle_tick();

        // Starvation: DM held high back-to-back, IF waiting
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000;
        if_req = 1'b1; if_addr = 64'h104;
        n_dm = 0; got_if = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem_en) begin
                if (mem_addr == 64'h104) begin got_if = 1; break; end
                n_dm++;
            end
        end
        check_eq("starve_dm_grants", n_dm, LIM);
        check_eq("starve_if_granted", got_if, 1);
        dm_req = 1'b0;
        wait_ack(1'b0, cyc, lat);
        idle_tick();

        // Reset while in WAIT: no capture, no ack afterwards
        if_req = 1'b1; if_addr = 64'h200;
        tick();
        tick();
        reset = 1'b1; if_req = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_if_ack", if_ack, 0);
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_ack += int'(if_ack) + int'(dm_ack);
        end
        check_eq("rst_no_late_ack", n_ack, 0);
        check_eq("rst_if_rdata", if_rdata, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            agents();
            tick();
        end
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        repeat (LAT + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the ARMv8 core between the instruction-fetch stage (IF port) and the load/store stage (DM port).
- Registers one request at a time, sequences the fixed-latency memory access, and returns data with a one-cycle ack pulse.
- Drives per-port stall signals into the pipeline control.
- Sits inside top, between the pipeline stages and the memory model.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; DATA_W/8 byte strobes.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; must be >= 1.
- STARVE_LIM, 4, consecutive DM grants while IF is waiting before IF is forced.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, registered.
- if_ack  out  1  one-cycle completion pulse.
- if_stall  out  1  if_req & ~if_ack.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_wstrb  in  DATA_W/8  store byte enables.
- dm_rdata  out  DATA_W  load data, registered.
- dm_ack  out  1  one-cycle completion pulse.
- dm_stall  out  1  dm_req & ~dm_ack.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_wstrb  out  DATA_W/8  byte enables.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE.
  - mem_en, mem_we, if_ack, dm_ack = 0.
  - mem_addr, mem_wdata, mem_wstrb, if_rdata, dm_rdata = 0.
  - starve_cnt = 0, lat_cnt = 0.
- States:
  - IDLE: sample requests. If either is high, latch the winner's address/data/strobe/we into the mem_* registers, set mem_en = 1 and record the owner. Next state is ISSUE.
  - ISSUE: mem_en is high during this single cycle. Clear mem_en. Load lat_cnt = MEM_LAT-1. Next state is WAIT.
  - WAIT: decrement lat_cnt. When lat_cnt == 0, capture mem_rdata into the owner's rdata (loads and fetches only; stores leave dm_rdata unchanged), then pulse the owner's ack. Next state is DONE.
  - DONE: the ack is high during this cycle only. No new grant is made. Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle t: mem_en at t+1, mem_rdata sampled at t+1+MEM_LAT, ack at t+2+MEM_LAT.
  - With defaults: ack at t+4. Throughput is one access per MEM_LAT+3 cycles.
- Priority:
  - Only one requester: it wins.
  - Both requesting: DM wins unless starve_cnt == STARVE_LIM, in which case IF wins.
- starve_cnt:
  - +1 (saturating) on a DM grant while if_req = 1.
  - Cleared on any IF grant, and on a DM grant with if_req = 0.
- Handshake:
  - A requester holds its req and payload stable until its ack.
  - Payload changes after the grant are ignored (latched copy is used).
  - A req dropped before it is granted is simply never served.
  - A req still high in the DONE cycle is not re-served, because DONE makes no grant.
  - Either port may present a new request in the cycle after its ack.
- Stores: same timing as loads. mem_we = 1 and mem_wstrb as latched. The ack confirms the write.
- Stalls: combinational from req/ack, no state.
- Reset mid-operation:
  - Aborts the in-flight access and returns to IDLE with all outputs at their reset values.
  - Any memory response arriving afterwards is ignored.

Decomposition:
- Constants go in the shared defines.v:
  - State encodings: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3.
  - Owner encoding: OWN_IF = 1'b0, OWN_DM = 1'b1.
  - Default MEM_LAT and STARVE_LIM.
- No sub-module is required. The latency counter stays inline.

Test Plan:
- Reset, then IF only: if_req = 1, if_addr = 0x100 at t, memory returns 0xD2800020 → mem_en at t+1 with mem_addr = 0x100; if_ack at t+4 with if_rdata = 0xD2800020; if_stall high t..t+3.
- Both requesters in the same IDLE cycle: DM load 0x2000 and IF 0x104 → DM is served first (dm_ack at t+4). IF is granted in the next IDLE (mem_addr = 0x104 at t+6) and acks at t+9.
- DM store: dm_we = 1, addr 0x3008, wdata 0xFFFF, wstrb 0x03 → one mem_en pulse with mem_we = 1, mem_wstrb = 0x03; dm_ack at t+4; dm_rdata unchanged.
- Starvation: dm_req held high for back-to-back loads with if_req held high → exactly 4 DM grants, then an IF grant, then starve_cnt = 0.
- Reset asserted in WAIT → next cycle state IDLE, acks 0, mem_en 0. The stale mem_rdata is not captured, and no ack occurs afterwards.
- Payload change after grant: dm_addr changes from 0x40 to 0x80 in ISSUE → mem_addr stays 0x40.
